// File: rtl/iob_eth_rx_drain_pkg.sv
// rtl/iob_eth_rx_drain_pkg.sv - shared states and constants for the receive drain block
package iob_eth_rx_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RD    = 3'd2,
    ST_LAT   = 3'd3,
    ST_OUT   = 3'd4,
    ST_ACK   = 3'd5,
    ST_CLR   = 3'd6
  } state_e;

  localparam int FCS_LEN      = 4;
  localparam int MAC_ADDR_LEN = 6;

  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/iob_eth_rx_drain_stat.sv
// rtl/iob_eth_rx_drain_stat.sv - forwarded/dropped frame counters, wrapping
module iob_eth_rx_drain_stat #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             inc_ok_i,
  input  logic             inc_drop_i,
  output logic [CNT_W-1:0] frames_ok_o,
  output logic [CNT_W-1:0] frames_drop_o
);

  logic [CNT_W-1:0] ok_q, ok_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  // next-state: each counter steps on its strobe and wraps naturally
  always_comb begin
    ok_d   = ok_q;
    drop_d = drop_q;
    if (inc_ok_i)   ok_d   = ok_q + CNT_W'(1);
    if (inc_drop_i) drop_d = drop_q + CNT_W'(1);
  end

  // counter registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ok_q   <= '0;
      drop_q <= '0;
    end else begin
      ok_q   <= ok_d;
      drop_q <= drop_d;
    end
  end

  assign frames_ok_o   = ok_q;
  assign frames_drop_o = drop_q;

endmodule

// File: rtl/iob_eth_rx_drain.sv
// rtl/iob_eth_rx_drain.sv - checks received frames and streams accepted ones without FCS; optional IOB_ETH_RX_DRAIN_FILTER_EN
module iob_eth_rx_drain
  import iob_eth_rx_drain_pkg::*;
#(
  parameter int BUF_ADDR_W = 11,
  parameter int MIN_LEN    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  buf_wr_i,
  input  logic [BUF_ADDR_W-1:0] buf_waddr_i,
  input  logic [7:0]            buf_wdata_i,
  input  logic                  data_rcvd_i,
  input  logic                  crc_err_i,
  output logic                  rcv_ack_o,
  input  logic [47:0]           mac_addr_i,
  output logic                  buf_rd_o,
  output logic [BUF_ADDR_W-1:0] buf_raddr_o,
  input  logic [7:0]            buf_rdata_i,
  output logic [7:0]            m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic [CNT_W-1:0]      frames_ok_o,
  output logic [CNT_W-1:0]      frames_drop_o
);

  // one extra bit so a completely full buffer still yields a correct length
  localparam int LEN_W = BUF_ADDR_W + 1;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [BUF_ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]            tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  ack;
  logic                  rd;
  logic                  inc_ok;
  logic                  inc_drop;
  logic                  filter_miss;
  logic                  drop;
  logic                  is_last_addr;

  // snoop: frame length follows the highest written address, cleared on ack
  always_comb begin
    len_d = len_q;
    if (ack) begin
      len_d = '0;
    end else if (buf_wr_i) begin
      len_d = {1'b0, buf_waddr_i} + LEN_W'(1);
    end
  end

  // length register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) len_q <= '0;
    else           len_q <= len_d;
  end

`ifdef IOB_ETH_RX_DRAIN_FILTER_EN
  logic [47:0] dest_q, dest_d;

  // snoop: capture the destination MAC from the first six buffer writes
  always_comb begin
    dest_d = dest_q;
    if (ack) begin
      dest_d = '0;
    end else if (buf_wr_i) begin
      for (int i = 0; i < MAC_ADDR_LEN; i++) begin
        if (buf_waddr_i == BUF_ADDR_W'(i)) dest_d[47-8*i -: 8] = buf_wdata_i;
      end
    end
  end

  // destination register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) dest_q <= '0;
    else           dest_q <= dest_d;
  end

  assign filter_miss = (dest_q != mac_addr_i) && (dest_q != BROADCAST_MAC);
`else
  // promiscuous: station address and written bytes play no part in the decision
  logic unused_filter_inputs;
  assign unused_filter_inputs = ^{mac_addr_i, buf_wdata_i};
  assign filter_miss          = 1'b0;
`endif

  assign drop         = crc_err_i || (len_q < LEN_W'(MIN_LEN)) || filter_miss;
  assign is_last_addr = ({1'b0, raddr_q} == (len_q - LEN_W'(FCS_LEN + 1)));

  // FSM next-state and output decode: check, then read/latch/offer one byte at a time
  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    rd       = 1'b0;
    ack      = 1'b0;
    inc_ok   = 1'b0;
    inc_drop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_rcvd_i) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (drop) begin
          inc_drop = 1'b1;
          state_d  = ST_ACK;
        end else begin
          raddr_d = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        rd      = 1'b1;
        state_d = ST_LAT;
      end
      ST_LAT: begin
        tdata_d  = buf_rdata_i;
        tvalid_d = 1'b1;
        tlast_d  = is_last_addr;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (m_tready_i) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            inc_ok  = 1'b1;
            state_d = ST_ACK;
          end else begin
            raddr_d = raddr_q + BUF_ADDR_W'(1);
            state_d = ST_RD;
          end
        end
      end
      ST_ACK: begin
        ack     = 1'b1;
        state_d = ST_CLR;
      end
      ST_CLR: begin
        // the receiver's done level may linger; wait it out so it is not counted twice
        if (!data_rcvd_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and stream output registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= ST_IDLE;
      raddr_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign rcv_ack_o   = ack;
  assign buf_rd_o    = rd;
  assign buf_raddr_o = raddr_q;
  assign m_tdata_o   = tdata_q;
  assign m_tvalid_o  = tvalid_q;
  assign m_tlast_o   = tlast_q;

  iob_eth_rx_drain_stat #(
    .CNT_W(CNT_W)
  ) u_stat (
    .clk_i         (clk_i),
    .arst_n_i      (arst_n_i),
    .inc_ok_i      (inc_ok),
    .inc_drop_i    (inc_drop),
    .frames_ok_o   (frames_ok_o),
    .frames_drop_o (frames_drop_o)
  );

endmodule

// File: tb/tb_iob_eth_rx_drain.sv
// tb/tb_iob_eth_rx_drain.sv - scoreboard bench for iob_eth_rx_drain
module tb_iob_eth_rx_drain;

  localparam int BUF_ADDR_W = 11;
  localparam int CNT_W      = 16;
  localparam logic [47:0] STATION = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER   = 48'h02_00_00_00_00_99;
  localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

  logic                  clk_i = 1'b0;
  logic                  arst_n_i = 1'b0;
  logic                  buf_wr_i = 1'b0;
  logic [BUF_ADDR_W-1:0] buf_waddr_i = '0;
  logic [7:0]            buf_wdata_i = '0;
  logic                  data_rcvd_i = 1'b0;
  logic                  crc_err_i = 1'b0;
  logic                  rcv_ack_o;
  logic [47:0]           mac_addr_i = STATION;
  logic                  buf_rd_o;
  logic [BUF_ADDR_W-1:0] buf_raddr_o;
  logic [7:0]            buf_rdata_i = '0;
  logic [7:0]            m_tdata_o;
  logic                  m_tvalid_o;
  logic                  m_tready_i = 1'b1;
  logic                  m_tlast_o;
  logic [CNT_W-1:0]      frames_ok_o;
  logic [CNT_W-1:0]      frames_drop_o;

  logic [7:0] mem [0:(1<<BUF_ADDR_W)-1];
  logic [8:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int exp_ok = 0;
  int exp_drop = 0;

  logic       held_v = 1'b0;
  logic [7:0] held_data;
  logic       held_last;

  iob_eth_rx_drain dut (
    .clk_i         (clk_i),
    .arst_n_i      (arst_n_i),
    .buf_wr_i      (buf_wr_i),
    .buf_waddr_i   (buf_waddr_i),
    .buf_wdata_i   (buf_wdata_i),
    .data_rcvd_i   (data_rcvd_i),
    .crc_err_i     (crc_err_i),
    .rcv_ack_o     (rcv_ack_o),
    .mac_addr_i    (mac_addr_i),
    .buf_rd_o      (buf_rd_o),
    .buf_raddr_o   (buf_raddr_o),
    .buf_rdata_i   (buf_rdata_i),
    .m_tdata_o     (m_tdata_o),
    .m_tvalid_o    (m_tvalid_o),
    .m_tready_i    (m_tready_i),
    .m_tlast_o     (m_tlast_o),
    .frames_ok_o   (frames_ok_o),
    .frames_drop_o (frames_drop_o)
  );

  always #5 clk_i = ~clk_i;

  // receiver frame buffer: write port from the bench, registered read port for the DUT
  always @(posedge clk_i) begin
    if (buf_wr_i) mem[buf_waddr_i] <= buf_wdata_i;
    if (buf_rd_o) buf_rdata_i <= mem[buf_raddr_o];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // output monitor: pops the scoreboard on each handshake, checks held data under backpressure
  always @(negedge clk_i) begin
    if (!arst_n_i) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("bp_hold", {m_tvalid_o, m_tlast_o, m_tdata_o}, {1'b1, held_last, held_data});
        held_v = 1'b0;
      end
      if (m_tvalid_o && m_tready_i) begin
        if (exp_q.size() == 0) chk("spurious_tvalid", m_tvalid_o, 1'b0);
        else chk("byte", {m_tlast_o, m_tdata_o}, exp_q.pop_front());
      end else if (m_tvalid_o) begin
        held_v    = 1'b1;
        held_data = m_tdata_o;
        held_last = m_tlast_o;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_frame(input int len, input logic [47:0] dest, input bit fwd);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = (i < 6) ? dest[47-8*i -: 8] : 8'(i);
      buf_wr_i    = 1'b1;
      buf_waddr_i = BUF_ADDR_W'(i);
      buf_wdata_i = b;
      if (fwd && i <= len - 5) exp_q.push_back({(i == len - 5), b});
      step();
    end
    buf_wr_i = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int budget, output int n);
    n = 0;
    while (!rcv_ack_o && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_ack_seen"}, rcv_ack_o, 1'b1);
    data_rcvd_i = 1'b0;
    crc_err_i   = 1'b0;
    step();
    chk({tag, "_ack_one_cycle"}, rcv_ack_o, 1'b0);
  endtask

  task automatic run_frame(input string tag, input int len, input logic [47:0] dest,
                           input bit crc, input bit fwd);
    int n;
    write_frame(len, dest, fwd);
    data_rcvd_i = 1'b1;
    crc_err_i   = crc;
    if (fwd) exp_ok++;
    else     exp_drop++;
    wait_ack(tag, 3 * len + 20, n);
    if (!fwd) chk({tag, "_ack_latency_le3"}, (n <= 3), 1'b1);
    repeat (2) step();
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_frames_ok"}, frames_ok_o, exp_ok);
    chk({tag, "_frames_drop"}, frames_drop_o, exp_drop);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fwd_other;
    int n;
`ifdef IOB_ETH_RX_DRAIN_FILTER_EN
    fwd_other = 1'b0;
`else
    fwd_other = 1'b1;
`endif
    step();
    chk("reset_outputs",
        {rcv_ack_o, buf_rd_o, buf_raddr_o, m_tdata_o, m_tvalid_o, m_tlast_o},
        '0);
    chk("reset_counters", {frames_ok_o, frames_drop_o}, '0);
    arst_n_i = 1'b1;
    repeat (2) step();

    run_frame("good64", 64, STATION, 1'b0, 1'b1);
    run_frame("crc100", 100, STATION, 1'b1, 1'b0);
    run_frame("runt40", 40, STATION, 1'b0, 1'b0);
    run_frame("runt63", 63, STATION, 1'b0, 1'b0);
    run_frame("bcast70", 70, BCAST, 1'b0, 1'b1);
    run_frame("other64", 64, OTHER, 1'b0, fwd_other);

    // backpressure in the middle of an 80-byte frame
    write_frame(80, STATION, 1'b1);
    data_rcvd_i = 1'b1;
    exp_ok++;
    repeat (30) step();
    m_tready_i = 1'b0;
    repeat (10) step();
    m_tready_i = 1'b1;
    wait_ack("bp80", 300, n);
    repeat (2) step();
    chk("bp80_drained", exp_q.size(), 0);
    chk("bp80_frames_ok", frames_ok_o, exp_ok);

    // asynchronous reset while a byte is being offered
    write_frame(64, STATION, 1'b1);
    data_rcvd_i = 1'b1;
    n = 0;
    while (!m_tvalid_o && n < 20) begin
      step();
      n++;
    end
    chk("rst_reach_out", m_tvalid_o, 1'b1);
    arst_n_i = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {rcv_ack_o, buf_rd_o, buf_raddr_o, m_tdata_o, m_tvalid_o, m_tlast_o},
        '0);
    chk("rst_mid_counters", {frames_ok_o, frames_drop_o}, '0);
    exp_q.delete();
    data_rcvd_i = 1'b0;
    exp_ok   = 0;
    exp_drop = 0;
    repeat (3) step();
    arst_n_i = 1'b1;
    repeat (2) step();
    run_frame("post_rst64", 64, STATION, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
